sseg_scan_decoder: RTL



---
 rtl/sseg_scan_decoder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder
// Passive reader for a 4-digit multiplexed seven-segment bus. Each scanned
// digit is sampled once per anode dwell after the anode has settled. The
// active-low segment pattern is decoded back to a hex value. A digit is
// committed only after several identical consecutive samples. The block
// never drives the display.
module sseg_scan_decoder #(
   parameter int SETTLE_CYC   = 4,
   parameter int STABLE_SCANS = 2,
   parameter int TIMEOUT_CYC  = 262144
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [7:0]  sseg,
   input  logic        err_clr,
   output logic [15:0] hex,
   output logic [3:0]  blank,
   output logic [3:0]  dp,
   output logic        update,
   output logic        err,
   output logic        idle
);

   localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [7:0]        SETTLE_MAX  = 8'(SETTLE_CYC);
   localparam logic [2:0]        STABLE_MAX  = 3'(STABLE_SCANS);
   localparam int                IDLE_W      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX    = IDLE_W'(TIMEOUT_CYC);
   localparam logic [IDLE_W-1:0] IDLE_ONE    = IDLE_W'(1);

   // Returns {legal, blank, value[3:0]} for a 7-bit active-low pattern.
   function automatic logic [5:0] seg_decode(input logic [6:0] seg);
      logic [5:0] r;
      case (seg)
         7'h40:   r = {2'b10, 4'h0};
         7'h79:   r = {2'b10, 4'h1};
         7'h24:   r = {2'b10, 4'h2};
         7'h30:   r = {2'b10, 4'h3};
         7'h19:   r = {2'b10, 4'h4};
         7'h12:   r = {2'b10, 4'h5};
         7'h02:   r = {2'b10, 4'h6};
         7'h78:   r = {2'b10, 4'h7};
         7'h00:   r = {2'b10, 4'h8};
         7'h10:   r = {2'b10, 4'h9};
         7'h08:   r = {2'b10, 4'hA};
         7'h03:   r = {2'b10, 4'hB};
         7'h46:   r = {2'b10, 4'hC};
         7'h21:   r = {2'b10, 4'hD};
         7'h06:   r = {2'b10, 4'hE};
         7'h0E:   r = {2'b10, 4'hF};
         7'h7F:   r = {2'b11, 4'h0};
         default: r = 6'b00_0000;
      endcase
      return r;
   endfunction

   // Returns {valid, index[1:0]}; valid only when exactly one anode is low.
   function automatic logic [2:0] anode_decode(input logic [3:0] a);
      logic [2:0] r;
      case (a)
         4'b1110: r = 3'b100;
         4'b1101: r = 3'b101;
         4'b1011: r = 3'b110;
         4'b0111: r = 3'b111;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   logic [3:0]        an_p0;
   logic [7:0]        sseg_p0;
   logic [3:0]        an_p1;
   logic [7:0]        settle_cnt_p1;
   logic [5:0]        cand_p2  [4];
   logic [2:0]        match_p2 [4];
   logic [3:0]        cand_vld_p2;
   logic [IDLE_W-1:0] idle_cnt_p2;

   logic [2:0]        an_dec;
   logic              an_ok;
   logic [1:0]        dig;
   logic              smp_vld_p1;
   logic [5:0]        seg_dec;
   logic              smp_legal;
   logic [5:0]        smp_fld;
   logic              cand_hit;
   logic [2:0]        match_nxt;
   logic              commit;
   logic [5:0]        cur_fld;
   logic              changed;

   // Sample-strobe generation, decode and commit decision for the sampled digit.
   always_comb begin
      an_dec     = anode_decode(an_p0);
      an_ok      = an_dec[2];
      dig        = an_dec[1:0];
      smp_vld_p1 = an_ok && (an_p0 == an_p1) && (settle_cnt_p1 == SETTLE_LAST);
      seg_dec    = seg_decode(sseg_p0[6:0]);
      smp_legal  = seg_dec[5];
      // Field layout {dp, blank, value}; dp on the bus is active-low.
      smp_fld    = {~sseg_p0[7], seg_dec[4:0]};
      cand_hit   = cand_vld_p2[dig] && (cand_p2[dig] == smp_fld);
      match_nxt  = 3'd1;
      if (cand_hit) begin
         match_nxt = (match_p2[dig] == 3'd7) ? 3'd7 : match_p2[dig] + 3'd1;
      end
      commit     = smp_vld_p1 && smp_legal && (match_nxt == STABLE_MAX);
      cur_fld    = {dp[dig], blank[dig], hex[{dig, 2'b00} +: 4]};
      changed    = (cur_fld != smp_fld);
   end

   // Stage p0: register the raw bus once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_p0   <= 4'hF;
         sseg_p0 <= 8'hFF;
      end else begin
         an_p0   <= an;
         sseg_p0 <= sseg;
      end
   end

   // Stage p1: settle counter, restarted on any anode change or invalid anode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_p1         <= 4'hF;
         settle_cnt_p1 <= 8'd0;
      end else begin
         an_p1 <= an_p0;
         if (!an_ok || (an_p0 != an_p1)) begin
            settle_cnt_p1 <= 8'd0;
         end else if (settle_cnt_p1 != SETTLE_MAX) begin
            settle_cnt_p1 <= settle_cnt_p1 + 8'd1;
         end
      end
   end

   // Stage p2: per-digit candidate tracking and commit to the output frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            cand_p2[i]  <= 6'd0;
            match_p2[i] <= 3'd0;
         end
         cand_vld_p2 <= 4'h0;
         hex         <= 16'h0000;
         blank       <= 4'hF;
         dp          <= 4'h0;
         update      <= 1'b0;
      end else begin
         update <= commit && changed;
         if (smp_vld_p1) begin
            if (smp_legal) begin
               cand_p2[dig]     <= smp_fld;
               cand_vld_p2[dig] <= 1'b1;
               match_p2[dig]    <= match_nxt;
            end else begin
               cand_vld_p2[dig] <= 1'b0;
               match_p2[dig]    <= 3'd0;
            end
         end
         if (commit) begin
            hex[{dig, 2'b00} +: 4] <= smp_fld[3:0];
            blank[dig]             <= smp_fld[4];
            dp[dig]                <= smp_fld[5];
         end
      end
   end

   // Sticky error flag; a new illegal sample wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (smp_vld_p1 && !smp_legal) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

   // Idle timer: counts cycles since the last sample of any kind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt_p2 <= '0;
      end else if (smp_vld_p1) begin
         idle_cnt_p2 <= '0;
      end else if (idle_cnt_p2 != IDLE_MAX) begin
         idle_cnt_p2 <= idle_cnt_p2 + IDLE_ONE;
      end
   end

   assign idle = (idle_cnt_p2 == IDLE_MAX);

endmodule
